cache_miss_controller: RTL

//  Sits directly upstream of memory_system, between the MIPS MEM stage and the cache.

---
 rtl/cache_miss_controller_pkg.sv | 20 ++
 rtl/cache_miss_controller_if.sv | 18 +
 rtl/cache_miss_controller_latency_timer.sv | 20 ++
 rtl/cache_miss_controller.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cache_miss_controller_pkg.sv
// Shared types and defaults for the MEM-stage cache miss controller.
package cache_miss_controller_pkg;
   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_ISSUE       = 3'd1,
      S_WB_WAIT     = 3'd2,
      S_FILL_WAIT   = 3'd3,
      S_FILL_COMMIT = 3'd4,
      S_DONE        = 3'd5
   } state_e;

   localparam int DEF_MISS_LATENCY = 20;
   localparam int DEF_WB_LATENCY   = 20;
   localparam int DEF_RETRY_MAX    = 1;
   localparam int CNT_W            = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/cache_miss_controller_if.sv
// Controller <-> cache strobe/data bus.
interface cache_miss_controller_if;
   logic        re;
   logic        we;
   logic        we2;
   logic        we3;
   logic [31:0] address;
   logic [31:0] writedata;
   logic [31:0] readdatacache;
   logic        hit;
   logic        miss;
   logic        dirty;

   modport master (output re, we, we2, we3, address, writedata,
                   input  readdatacache, hit, miss, dirty);
   modport slave  (input  re, we, we2, we3, address, writedata,
                   output readdatacache, hit, miss, dirty);
endinterface

// File: rtl/cache_miss_controller_latency_timer.sv
// Loadable down-counter; done while the count sits at zero.
module cache_miss_controller_latency_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt <= '0;
      else if (load)          cnt <= load_val;
      else if (cnt != '0)     cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);
endmodule

// File: rtl/cache_miss_controller.sv
// Stalls the MEM stage on a cache miss, sequences writeback/refill, replays the access.
module cache_miss_controller
   import cache_miss_controller_pkg::*;
#(
   parameter int MISS_LATENCY = DEF_MISS_LATENCY,
   parameter int WB_LATENCY   = DEF_WB_LATENCY,
   parameter int RETRY_MAX    = DEF_RETRY_MAX
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   output logic             stall,
   output logic [31:0]      load_data,
   output logic             load_valid,
   output logic             err,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   cache_miss_controller_if.master cache
);
   localparam int MAXL = (MISS_LATENCY > WB_LATENCY) ? MISS_LATENCY : WB_LATENCY;
   localparam int TW   = $clog2(MAXL + 1);
   localparam int RW   = $clog2(RETRY_MAX + 2);

   state_e        state, nxt;
   logic          op_wr, replay_q;
   logic [RW-1:0] retry_q;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic          req, retry_exceed;
   logic          tmr_load, tmr_done;
   logic [TW-1:0] tmr_val;

   assign req          = mem_read | mem_write;
   assign retry_exceed = replay_q && ((int'(retry_q) + 1) > RETRY_MAX);

   cache_miss_controller_latency_timer #(.W(TW)) u_tmr (
      .clk      (clk),
      .rst_n    (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= nxt;
   end

   // Timer is loaded with LAT-1 so a wait state lasts exactly LAT cycles.
   always_comb begin
      nxt      = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         S_IDLE:        if (req) nxt = S_ISSUE;
         S_ISSUE: begin
            if (cache.hit || retry_exceed) nxt = S_DONE;
            else if (cache.dirty) begin
               nxt      = S_WB_WAIT;
               tmr_load = 1'b1;
               tmr_val  = TW'(WB_LATENCY - 1);
            end else begin
               nxt      = S_FILL_WAIT;
               tmr_load = 1'b1;
               tmr_val  = TW'(MISS_LATENCY - 1);
            end
         end
         S_WB_WAIT: if (tmr_done) begin
            nxt      = S_FILL_WAIT;
            tmr_load = 1'b1;
            tmr_val  = TW'(MISS_LATENCY - 1);
         end
         S_FILL_WAIT:   if (tmr_done) nxt = S_FILL_COMMIT;
         S_FILL_COMMIT: nxt = S_ISSUE;
         S_DONE:        nxt = S_IDLE;
         default:       nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_wr      <= 1'b0;
         replay_q   <= 1'b0;
         retry_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err        <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            S_IDLE: if (req) begin
               op_wr    <= mem_write;
               addr_q   <= mem_addr;
               wdata_q  <= mem_wdata;
               replay_q <= 1'b0;
               retry_q  <= '0;
            end
            S_ISSUE: begin
               rdata_q <= cache.hit ? cache.readdatacache : 32'h0;
               if (!replay_q) begin
                  if (cache.hit) hit_count  <= sat_inc(hit_count);
                  else           miss_count <= sat_inc(miss_count);
               end
               if (!cache.hit && replay_q) begin
                  retry_q <= retry_q + 1'b1;
                  if (retry_exceed) err <= 1'b1;
               end
            end
            S_FILL_COMMIT: replay_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Reset gating keeps stall low while reset is held, even with a request pending.
   assign stall      = reset_n & (((state == S_IDLE) & req) |
                                  ((state != S_IDLE) & (state != S_DONE)));
   assign load_valid = (state == S_DONE) & ~op_wr;
   assign load_data  = load_valid ? rdata_q : 32'h0;

   assign cache.re        = (state == S_ISSUE) & ~op_wr;
   assign cache.we        = (state == S_ISSUE) &  op_wr;
   assign cache.we2       = (state == S_FILL_COMMIT) &  op_wr;
   assign cache.we3       = (state == S_FILL_COMMIT) & ~op_wr;
   assign cache.address   = addr_q;
   assign cache.writedata = wdata_q;
endmodule
